// File: rtl/fp_pkg.sv
// Shared constants and state encoding for the binary32 converter family.
package fp_pkg;

    typedef enum logic [2:0] {
        GET_A,
        CONVERT,
        NORMALISE,
        ROUND,
        PACK,
        PUT_RESULT
    } state_t;

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

    localparam logic [31:0] FP_POS_ZERO = 32'h00000000;

endpackage

// File: rtl/lzc32.sv
// Combinational leading-zero counter for a 32-bit word; an all-zero word reports 32.
module lzc32 (
    input  logic [31:0] value,
    output logic [5:0]  count
);

    // Scanning upward lets the highest set bit make the final assignment.
    always_comb begin
        count = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (value[i]) begin
                count = 6'(31 - i);
            end
        end
    end

endmodule

// File: rtl/int_to_float.sv
// Signed 32-bit integer to IEEE-754 binary32 converter, round-to-nearest-even.
// Define ITOF_FAST_NORM_EN for single-cycle normalisation via lzc32 and a barrel shift.
module int_to_float
    import fp_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] input_a,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] output_result,
    output logic        out_valid,
    input  logic        out_ready
);

    state_t state;

    logic [31:0]          a_reg;
    logic [31:0]          value;
    logic                 sign;
    logic [FP_EXP_W-1:0]  exponent;
    logic [FP_MANT_W-1:0] mantissa;

    logic        guard;
    logic        round_bit;
    logic        sticky;
    logic        round_up;
    logic [23:0] rounded_frac;

    assign in_ready = (state == GET_A);

    // The hidden bit value[31] is always set here, so a full 24-bit mantissa of
    // all ones is exactly a 23-bit fraction of all ones carrying into bit 23.
    assign guard        = value[7];
    assign round_bit    = value[6];
    assign sticky       = |value[5:0];
    assign round_up     = guard & (round_bit | sticky | value[8]);
    assign rounded_frac = {1'b0, value[30:8]} + {23'd0, round_up};

`ifdef ITOF_FAST_NORM_EN
    logic [5:0] lz;

    lzc32 u_lzc (
        .value (value),
        .count (lz)
    );
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= GET_A;
            out_valid     <= 1'b0;
            output_result <= FP_POS_ZERO;
            a_reg         <= 32'd0;
            value         <= 32'd0;
            sign          <= 1'b0;
            exponent      <= '0;
            mantissa      <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (in_valid) begin
                        a_reg <= input_a;
                        state <= CONVERT;
                    end
                end

                CONVERT: begin
                    if (a_reg == 32'd0) begin
                        output_result <= FP_POS_ZERO;
                        out_valid     <= 1'b1;
                        state         <= PUT_RESULT;
                    end else begin
                        sign     <= a_reg[31];
                        value    <= a_reg[31] ? (~a_reg + 32'd1) : a_reg;
                        exponent <= 8'd31;
                        state    <= NORMALISE;
                    end
                end

                NORMALISE: begin
`ifdef ITOF_FAST_NORM_EN
                    value    <= value << lz;
                    exponent <= 8'd31 - {2'b00, lz};
                    state    <= ROUND;
`else
                    if (!value[31]) begin
                        value    <= value << 1;
                        exponent <= exponent - 8'd1;
                    end else begin
                        state <= ROUND;
                    end
`endif
                end

                ROUND: begin
                    mantissa <= rounded_frac[22:0];
                    if (rounded_frac[23]) begin
                        exponent <= exponent + 8'd1;
                    end
                    state <= PACK;
                end

                PACK: begin
                    output_result <= {sign, exponent + 8'(FP_BIAS), mantissa};
                    out_valid     <= 1'b1;
                    state         <= PUT_RESULT;
                end

                PUT_RESULT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= GET_A;
                    end
                end

                default: state <= GET_A;
            endcase
        end
    end

endmodule

// File: tb/tb_int_to_float.sv
// Directed-vector bench for int_to_float; expected latencies follow ITOF_FAST_NORM_EN.
module tb_int_to_float;

    logic        clk;
    logic        rst;
    logic [31:0] input_a;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] output_result;
    logic        out_valid;
    logic        out_ready;

    int total = 0;
    int bad   = 0;

    int_to_float dut (
        .clk           (clk),
        .rst           (rst),
        .input_a       (input_a),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .output_result (output_result),
        .out_valid     (out_valid),
        .out_ready     (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // lz < 0 marks a zero operand.
    function automatic int expLatency(input int lz);
        if (lz < 0) return 1;
`ifdef ITOF_FAST_NORM_EN
        return 4;
`else
        return 4 + lz;
`endif
    endfunction

    // Present one operand, measure edges from accept to out_valid, then hold
    // the result for 'hold' cycles of backpressure before the handshake.
    task automatic applyStimulus(input string tag, input logic [31:0] a,
                                 input logic [31:0] expected, input int lz, input int hold);
        int cycles;
        logic [31:0] held;
        @(negedge clk);
        input_a  = a;
        in_valid = 1'b1;
        cycles = 0;
        while (!in_ready && cycles < 100) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, " ready"}, {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        input_a  = 32'hDEADBEEF;
        cycles = 0;
        while (!out_valid && cycles < 200) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, " latency"}, 32'(cycles), 32'(expLatency(lz)));
        checkOutput({tag, " result"}, output_result, expected);
        held = output_result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, " hold result"}, output_result, held);
            checkOutput({tag, " hold valid"}, {31'd0, out_valid}, 32'd1);
            checkOutput({tag, " hold busy"}, {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, " valid drop"}, {31'd0, out_valid}, 32'd0);
        checkOutput({tag, " idle"}, {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        input_a   = 32'd0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset result", output_result, 32'd0);
        checkOutput("reset ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;

        applyStimulus("one",       32'd1,        32'h3F800000, 31, 0);
        applyStimulus("minus one", 32'hFFFFFFFF, 32'hBF800000, 31, 0);
        applyStimulus("zero",      32'd0,        32'h00000000, -1, 0);
        applyStimulus("int min",   32'h80000000, 32'hCF000000, 0,  0);
        applyStimulus("int max",   32'h7FFFFFFF, 32'h4F000000, 1,  0);
        applyStimulus("1000",      32'd1000,     32'h447A0000, 22, 0);
        applyStimulus("tie down",  32'd16777217, 32'h4B800000, 7,  0);
        applyStimulus("tie up",    32'd16777219, 32'h4B800002, 7,  0);
        applyStimulus("tie down2", 32'd16777221, 32'h4B800002, 7,  0);
        applyStimulus("exact",     32'd16777222, 32'h4B800003, 7,  0);
        applyStimulus("backpress", 32'd16777219, 32'h4B800002, 7,  10);

        // Abort a conversion of 5 while it sits in NORMALISE.
        @(negedge clk);
        input_a  = 32'd5;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("abort valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort ready", {31'd0, in_ready}, 32'd1);

        applyStimulus("after abort", 32'd7, 32'h40E00000, 29, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
